// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the unified data-memory port: default widths,
// arbiter state encodings and requester indices (also used by the CPU top).
package dmem_port_arbiter_pkg;

    localparam int DBITS_DEFAULT = 16;
    localparam int ABITS_DEFAULT = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that did not win last time.
module rr_pick2
    import dmem_port_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = REQ_CPU;
        if (req0 && req1) begin
            winner = (last == REQ_CPU) ? REQ_DBG : REQ_CPU;
        end else if (req1) begin
            winner = REQ_DBG;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Serialises CPU and debug-loader accesses onto the single registered data
// port of the unified memory, returning read data with a per-requester strobe.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int DBITS = DBITS_DEFAULT,
    parameter int ABITS = ABITS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [DBITS-1:0] addr0,
    input  logic [DBITS-1:0] addr1,
    input  logic [DBITS-1:0] wdata0,
    input  logic [DBITS-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [DBITS-1:0] rdata,
    output logic [ABITS-1:0] maddr,
    output logic             mwe,
    output logic [DBITS-1:0] mdin,
    input  logic [DBITS-1:0] mdout
);

    arb_state_t state;
    arb_state_t state_nxt;

    logic last;
    logic owner;
    logic lat_we;
    logic in_range;

    logic pick_valid;
    logic pick_winner;

    logic             win_we;
    logic [DBITS-1:0] win_addr;
    logic [DBITS-1:0] win_wdata;
    logic             win_in_range;

    logic take;
    logic rdata_load;
    logic gnt0_nxt;
    logic gnt1_nxt;
    logic mwe_nxt;
    logic rvalid0_nxt;
    logic rvalid1_nxt;

    rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    assign win_we       = (pick_winner == REQ_DBG) ? we1    : we0;
    assign win_addr     = (pick_winner == REQ_DBG) ? addr1  : addr0;
    assign win_wdata    = (pick_winner == REQ_DBG) ? wdata1 : wdata0;
    // Anything above the memory's byte span is granted but never reaches the array.
    assign win_in_range = (win_addr[DBITS-1:ABITS+1] == '0);

    always_comb begin
        state_nxt   = state;
        take        = 1'b0;
        rdata_load  = 1'b0;
        gnt0_nxt    = 1'b0;
        gnt1_nxt    = 1'b0;
        mwe_nxt     = 1'b0;
        rvalid0_nxt = 1'b0;
        rvalid1_nxt = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    take      = 1'b1;
                    state_nxt = ST_ISSUE;
                    gnt0_nxt  = (pick_winner == REQ_CPU);
                    gnt1_nxt  = (pick_winner == REQ_DBG);
                    mwe_nxt   = win_we & win_in_range;
                end
            end
            ST_ISSUE: begin
                state_nxt = lat_we ? ST_IDLE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_nxt   = ST_IDLE;
                rdata_load  = 1'b1;
                rvalid0_nxt = (owner == REQ_CPU);
                rvalid1_nxt = (owner == REQ_DBG);
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Port outputs are loaded on the edge entering ISSUE so they are stable for the whole ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            last     <= REQ_DBG;
            owner    <= REQ_CPU;
            lat_we   <= 1'b0;
            in_range <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            mwe      <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            maddr    <= '0;
            mdin     <= '0;
            rdata    <= '0;
        end else begin
            state   <= state_nxt;
            gnt0    <= gnt0_nxt;
            gnt1    <= gnt1_nxt;
            mwe     <= mwe_nxt;
            rvalid0 <= rvalid0_nxt;
            rvalid1 <= rvalid1_nxt;
            if (take) begin
                last     <= pick_winner;
                owner    <= pick_winner;
                lat_we   <= win_we;
                in_range <= win_in_range;
                maddr    <= win_addr[ABITS:1];
                mdin     <= win_wdata;
            end
            if (rdata_load) begin
                rdata <= in_range ? mdout : '0;
            end
        end
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter and sequencer for the single data port of the processor's unified memory array. Requester 0 is the CPU data path (LW/SW). Requester 1 is the debug/program-loader port. The block serialises their accesses onto one registered address/write-data/write-enable set. It returns read data with a valid strobe, and arbitrates round-robin so neither side starves.

## Interface
Parameters:
- DBITS, 16, data and byte-address width
- ABITS, 12, memory word-address width; memory spans byte addresses 0 .. 2^(ABITS+1)-2

Ports:
- CLK  in  1  single clock, all state on posedge
- RESETN  in  1  reset, asynchronous, active-low
- REQ0, REQ1  in  1 each  access request; held until the matching GNT
- WE0, WE1  in  1 each  1 = write, 0 = read; held with REQ
- ADDR0, ADDR1  in  DBITS each  byte address; bit 0 ignored
- WDATA0, WDATA1  in  DBITS each  write data
- GNT0, GNT1  out  1 each  one-cycle pulse; request accepted, requester may drop REQ
- RVALID0, RVALID1  out  1 each  one-cycle pulse; RDATA valid for a granted read
- RDATA  out  DBITS  read data, shared by both requesters
- MADDR  out  ABITS  memory word address (= ADDR[ABITS:1])
- MWE  out  1  memory write enable
- MDIN  out  DBITS  memory write data
- MDOUT  in  DBITS  memory read data, registered in memory (1-cycle latency after MADDR)

## Operation
- States: IDLE, ISSUE, CAPTURE.
- IDLE:
  - No REQ: stay in IDLE.
  - Otherwise select a winner and go to ISSUE.
  - Latch the winner's ADDR/WE/WDATA, its index (OWNER) and a range flag.
  - INRANGE = (ADDR[DBITS-1:ABITS+1] == 0).
- Selection rule:
  - Only one REQ high: that requester wins.
  - Both high: the requester not equal to LAST wins.
  - LAST updates to the winner on every grant.
- ISSUE:
  - GNT[OWNER] = 1 and MADDR = latched word address.
  - MWE = latched WE & INRANGE; MDIN = latched WDATA.
  - Write: next state IDLE.
  - Read: next state CAPTURE.
- CAPTURE:
  - RDATA <= INRANGE ? MDOUT : 0.
  - RVALID[OWNER] pulses in the following IDLE cycle.
  - Next state IDLE.
- Out-of-range accesses:
  - Still granted.
  - Writes are dropped (MWE stays 0).
  - Reads return 0.
  - Memory-mapped I/O decode stays outside this block.
- REQ dropped before GNT: behaviour undefined. The bench does not drive it.
- REQ held after GNT: treated as a new request at the next IDLE.

## Timing
- Reset values:
  - state = IDLE, LAST = 1 (requester 0 wins the first tie).
  - GNT0/1 = 0, RVALID0/1 = 0, MWE = 0.
  - MADDR = 0, MDIN = 0, RDATA = 0.
- All outputs are registered; no combinational REQ→GNT path.
- Write: REQ sampled at edge e → GNT and MWE high in cycle e+1 → memory writes at edge e+2. Throughput is 1 write per 2 cycles.
- Read: REQ sampled at edge e → GNT in e+1 → MDOUT valid in e+2 → RVALID and RDATA in e+3.
  - The next grant can be sampled at edge e+3, so RVALID and the next GNT may coincide.
  - Throughput is 1 read per 3 cycles.
- Simultaneous REQ0/REQ1 with both held: grants alternate 0,1,0,1… Worst-case wait for either requester is one foreign access (≤3 cycles).
- RESETN low mid-access:
  - Immediately: MWE=0, GNT=0, RVALID=0, state=IDLE.
  - The in-flight access is abandoned and RVALID is never issued for it.
  - Release is synchronous with the next posedge.
- Address wrap: MADDR takes ADDR[ABITS:1] only; upper bits never alias into memory.

## Structure
- Shared package/header, also used by the CPU top level:
  - DBITS and ABITS defaults.
  - State encodings ST_IDLE, ST_ISSUE, ST_CAPTURE.
  - Requester index constants REQ_CPU=0, REQ_DBG=1.
- One sub-module, rr_pick2: 2-way round-robin pick with inputs REQ0, REQ1, LAST and outputs VALID, WINNER. Pure combinational.
- FSM, latches and output registers live in dmem_port_arbiter.
- Target size: about 150–250 lines.

## Test plan
- Reset, then REQ0 write of ADDR0=16'h0104, WDATA0=16'h1234 → GNT0 in cycle 1, MWE=1, MADDR=12'h082, MDIN=16'h1234; then MWE=0.
- Preload word 12'h082=16'hBEEF; REQ1 read ADDR1=16'h0104 → GNT1 at +1, RVALID1 at +3 with RDATA=16'hBEEF; RVALID0 stays 0.
- REQ0 and REQ1 both held for 8 reads from reset → grant order 0,1,0,1, with matching RVALIDs and no cycle where both GNTs are high.
- REQ0 write to 16'hFFF8 (out of range) → GNT0 pulses, MWE stays 0. REQ0 read of 16'hFFFA → RDATA=0 with RVALID0.
- Pull RESETN low in the ISSUE cycle of a write → MWE drops the same cycle, memory is unchanged, no RVALID, first post-reset tie goes to requester 0.
- REQ1 held continuously while REQ0 issues back-to-back writes → REQ1 granted at the second arbitration; no more than one REQ0 grant between REQ1 grants.
